puf_response_collector: RTL and testbench
=========================================

# puf_response_collector

Sequencer and response accumulator that sits directly downstream of one DelayPUF instance in the wrapped OpenPUF design. On a start pulse it walks a run of consecutive 8-bit challenges. For each challenge it evaluates the PUF several times and majority-votes the result bit. It shifts the voted bits into a response word that firmware reads over the logic-analyzer bus, and it counts non-unanimous (unstable) bits as a reliability metric.

## Interface
Parameters:
- RESP_BITS, 32: response word width, one bit per challenge (1..32).
- VOTES, 5: evaluations per challenge; must be odd, 1..15.
- SETTLE, 16: cycles waited after the run pulse before sampling `puf_result` (1..255).

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin acquisition; sampled only in IDLE.
- seed  in  8  first challenge, captured on accepted start.
- puf_result  in  1  DelayPUF result bit.
- puf_reset  out  1  active-high reset to DelayPUF.
- puf_run  out  1  one-cycle run pulse to DelayPUF.
- puf_challenge  out  8  challenge driven to DelayPUF.
- response  out  RESP_BITS  accumulated voted response.
- unstable_cnt  out  6  number of bits whose votes were not unanimous.
- busy  out  1  acquisition in progress.
- done  out  1  one-cycle pulse when the response is complete.

## Operation
- States: IDLE, CLEAR, RUN, SETTLE, SAMPLE, COMMIT, DONE.
- IDLE, start=1:
  - capture seed into the challenge register;
  - clear response, unstable_cnt, bit counter, vote counter and ones counter;
  - go to CLEAR.
- CLEAR: 2 cycles, puf_reset=1. Then go to RUN.
- RUN: 1 cycle, puf_run=1. Then go to SETTLE.
- SETTLE: exactly SETTLE cycles with both control outputs low. Then go to SAMPLE.
- SAMPLE: 1 cycle.
  - ones += puf_result; votes += 1.
  - If votes == VOTES, go to COMMIT; otherwise go to CLEAR.
- COMMIT: 1 cycle.
  - Voted bit = (ones > VOTES/2). Shift it in: response <= {response[RESP_BITS-2:0], bit}. The first bit ends up at the MSB.
  - If ones != 0 and ones != VOTES, increment unstable_cnt.
  - challenge <= challenge + 1 (mod 256; 0xFF wraps to 0x00).
  - Clear votes and ones; bits += 1.
  - If bits == RESP_BITS, go to DONE; otherwise go to CLEAR.
- DONE: 1 cycle, done=1. Then go to IDLE.
- Hold behaviour: response and unstable_cnt hold until the next accepted start. puf_challenge continuously drives the challenge register.
- start in any state other than IDLE is ignored, including in the DONE cycle.
- Ones counter is 4 bits; unstable_cnt saturates at RESP_BITS, which needs no saturation logic.

## Timing
- Reset (reset_n=0 at a rising edge) from any state, including mid-acquisition:
  - next state IDLE;
  - response=0, unstable_cnt=0, puf_challenge=0x00;
  - puf_reset=0, puf_run=0, busy=0, done=0.
  - No partial result is kept.
- All outputs are registered or decoded from state; none combinationally depend on `start` or `puf_result`.
- Start accepted at edge E0: busy=1 from the cycle after E0.
- Per-vote cost: 2 + 1 + SETTLE + 1 = SETTLE+4 cycles.
- Per-bit cost: VOTES*(SETTLE+4)+1 cycles.
- busy stays high for RESP_BITS*(VOTES*(SETTLE+4)+1) cycles. With defaults that is 32*(5*20+1) = 3232.
- done is high in the cycle immediately after busy falls (cycle 3233 after E0 with defaults). busy=0 during DONE.
- puf_result is sampled in the SAMPLE cycle, which is SETTLE+1 cycles after the RUN cycle.
- puf_challenge is stable from the COMMIT edge through the whole next bit's CLEAR/RUN/SETTLE/SAMPLE cycles.

## Test plan
- Reset defaults: hold reset_n=0 for 3 cycles, then release -> all outputs 0, state IDLE; start ignored while reset_n=0.
- Stuck-high PUF: defaults, seed=0x10, puf_result tied to 1 -> done exactly 3233 cycles after start; response=0xFFFFFFFF; unstable_cnt=0; last puf_challenge=0x30.
- Challenge-dependent model: puf_result = challenge[0], seed=0xFE -> challenge wraps 0xFF to 0x00; response=0x55555555 (first bit 0 from 0xFE); unstable_cnt=0.
- Noisy votes: VOTES=5, model returns 1,1,0,1,0 per bit -> every voted bit=1; unstable_cnt=32; 2-of-5 ones pattern -> bit=0.
- Protocol: check puf_reset high 2 cycles, puf_run high 1 cycle, sample exactly SETTLE+1 cycles after run (model toggles puf_result one cycle early or late -> vote changes); start pulsed while busy -> no restart, timing unchanged.
- Reset mid-op: drop reset_n at cycle 1500 -> IDLE next cycle, response=0, done never pulses; a new start then completes normally.

Source files
------------

// File: rtl/puf_response_collector.sv
// -----------------------------------------------------------------------------
// puf_response_collector
//
// Drives one DelayPUF through a run of consecutive 8-bit challenges. Each
// challenge is evaluated VOTES times (clear, run, settle, sample), the samples
// are majority-voted into one response bit, and the bits are shifted into a
// RESP_BITS-wide response word, first bit ending at the MSB. Bits whose votes
// were not unanimous are counted in unstable_cnt.
//
// Parameters:
//   RESP_BITS  response width, one bit per challenge (1..32)
//   VOTES      evaluations per challenge, odd, 1..15
//   SETTLE     idle cycles between the run pulse and sampling (1..255)
//
// Ports:
//   clk            system clock
//   reset_n        synchronous active-low reset
//   start          begin acquisition (only honoured in IDLE)
//   seed           first challenge, captured on accepted start
//   puf_result     DelayPUF result bit, sampled in SAMPLE
//   puf_reset      active-high DelayPUF reset (CLEAR state)
//   puf_run        one-cycle DelayPUF run pulse (RUN state)
//   puf_challenge  current challenge register
//   response       accumulated voted response
//   unstable_cnt   number of non-unanimous bits
//   busy           acquisition in progress
//   done           one-cycle completion pulse
// -----------------------------------------------------------------------------
module puf_response_collector #(
    parameter int RESP_BITS = 32,
    parameter int VOTES     = 5,
    parameter int SETTLE    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [7:0]           seed,
    input  logic                 puf_result,
    output logic                 puf_reset,
    output logic                 puf_run,
    output logic [7:0]           puf_challenge,
    output logic [RESP_BITS-1:0] response,
    output logic [5:0]           unstable_cnt,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_SAMPLE,
        S_COMMIT,
        S_DONE
    } state_t;

    localparam logic [7:0] CLEAR_LAST  = 8'd1;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [3:0] VOTES_N     = 4'(VOTES);
    localparam logic [3:0] VOTES_HALF  = 4'(VOTES / 2);
    localparam logic [5:0] BITS_N      = 6'(RESP_BITS);

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;       // cycle counter inside CLEAR / SETTLE
    logic [7:0]           chal_q, chal_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic [5:0]           unst_q, unst_d;
    logic [5:0]           bits_q, bits_d;
    logic [3:0]           votes_q, votes_d;
    logic [3:0]           ones_q, ones_d;

    logic                 voted_bit;
    logic                 unanimous;
    logic [3:0]           votes_inc;
    logic [5:0]           bits_inc;
    logic [RESP_BITS:0]   shift_w;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chal_d    = chal_q;
        resp_d    = resp_q;
        unst_d    = unst_q;
        bits_d    = bits_q;
        votes_d   = votes_q;
        ones_d    = ones_q;

        voted_bit = (ones_q > VOTES_HALF);
        unanimous = (ones_q == 4'd0) || (ones_q == VOTES_N);
        votes_inc = votes_q + 4'd1;
        bits_inc  = bits_q + 6'd1;
        // Concatenate then keep the low RESP_BITS bits so RESP_BITS=1 needs
        // no special-case slice.
        shift_w   = {resp_q, voted_bit};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    chal_d  = seed;
                    resp_d  = '0;
                    unst_d  = '0;
                    bits_d  = '0;
                    votes_d = '0;
                    ones_d  = '0;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CLEAR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SAMPLE: begin
                ones_d  = ones_q + {3'b000, puf_result};
                votes_d = votes_inc;
                if (votes_inc == VOTES_N) begin
                    state_d = S_COMMIT;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_COMMIT: begin
                resp_d  = shift_w[RESP_BITS-1:0];
                if (!unanimous) begin
                    unst_d = unst_q + 6'd1;
                end
                chal_d  = chal_q + 8'd1;
                votes_d = '0;
                ones_d  = '0;
                bits_d  = bits_inc;
                if (bits_inc == BITS_N) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            chal_q  <= '0;
            resp_q  <= '0;
            unst_q  <= '0;
            bits_q  <= '0;
            votes_q <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chal_q  <= chal_d;
            resp_q  <= resp_d;
            unst_q  <= unst_d;
            bits_q  <= bits_d;
            votes_q <= votes_d;
            ones_q  <= ones_d;
        end
    end

    // Control outputs are pure state decodes, so none depend on start or
    // puf_result combinationally.
    assign puf_reset     = (state_q == S_CLEAR);
    assign puf_run       = (state_q == S_RUN);
    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done          = (state_q == S_DONE);
    assign puf_challenge = chal_q;
    assign response      = resp_q;
    assign unstable_cnt  = unst_q;

endmodule

// File: tb/tb_puf_response_collector.sv
// -----------------------------------------------------------------------------
// tb_puf_response_collector
//
// Directed bench for puf_response_collector with default parameters. A small
// behavioural DelayPUF model answers according to the selected mode; expected
// results are pushed when each acquisition is started and compared by the
// monitor when done pulses.
// -----------------------------------------------------------------------------
module tb_puf_response_collector;

    localparam int RESP_BITS = 32;
    localparam int VOTES     = 5;
    localparam int SETTLE    = 16;
    localparam int BUSY_LEN  = RESP_BITS * (VOTES * (SETTLE + 4) + 1); // 3232

    logic                 clk;
    logic                 reset_n;
    logic                 start;
    logic [7:0]           seed;
    logic                 puf_result;
    logic                 puf_reset;
    logic                 puf_run;
    logic [7:0]           puf_challenge;
    logic [RESP_BITS-1:0] response;
    logic [5:0]           unstable_cnt;
    logic                 busy;
    logic                 done;

    puf_response_collector #(
        .RESP_BITS (RESP_BITS),
        .VOTES     (VOTES),
        .SETTLE    (SETTLE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .seed          (seed),
        .puf_result    (puf_result),
        .puf_reset     (puf_reset),
        .puf_run       (puf_run),
        .puf_challenge (puf_challenge),
        .response      (response),
        .unstable_cnt  (unstable_cnt),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] resp;
        logic [5:0]  unst;
        logic [7:0]  chal;
        int          start_cyc;
    } done_exp_t;

    done_exp_t   done_q[$];
    logic [49:0] snap_q[$];   // {busy,done,puf_reset,puf_run,chal,unst,resp}

    int n_vec    = 0;
    int n_err    = 0;
    int tmo_req  = 0;
    int tmo_seen = 0;
    int mode     = 0;

    // ---------------- DelayPUF model ----------------
    // 0: stuck high   1: challenge[0]   2: votes 1,1,0,1,0
    // 3: votes 1,1,0,0,0   4: high only exactly SETTLE+1 cycles after run
    int runs  = 0;
    int since = 1000;
    int idx;
    always @(negedge clk) begin
        if (!busy) runs = 0;
        else if (puf_run) runs = runs + 1;
        if (puf_run) since = 0;
        else if (since < 1000) since = since + 1;
        idx = (runs == 0) ? 0 : (runs - 1) % 5;
        case (mode)
            0: puf_result = 1'b1;
            1: puf_result = puf_challenge[0];
            2: puf_result = (idx == 0) || (idx == 1) || (idx == 3);
            3: puf_result = (idx == 0) || (idx == 1);
            4: puf_result = (since == SETTLE + 1);
            default: puf_result = 1'b0;
        endcase
    end

    // ---------------- monitor ----------------
    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    int          rlen     = 0;
    int          plen     = 0;
    int          busy_len = 0;
    done_exp_t   e;
    logic [49:0] s;

    always @(negedge clk) begin
        if (tmo_req != tmo_seen) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL done_timeout: done not seen, got %0d expired waits, required 0",
                     tmo_req - tmo_seen);
            tmo_seen = tmo_req;
        end

        if (snap_q.size() != 0) begin
            s = snap_q.pop_front();
            chk("idle_snapshot",
                {busy, done, puf_reset, puf_run, puf_challenge, unstable_cnt, response}, s);
        end

        if (reset_n && done) begin
            if (done_q.size() == 0) begin
                n_vec = n_vec + 1;
                n_err = n_err + 1;
                $display("FAIL unexpected_done: got done=1, required 0 (no acquisition pending)");
            end else begin
                e = done_q.pop_front();
                chk("response", response, e.resp);
                chk("unstable_cnt", unstable_cnt, e.unst);
                chk("last_challenge", puf_challenge, e.chal);
                chk("done_latency", cyc - e.start_cyc, BUSY_LEN + 1);
                chk("busy_cycles", busy_len, BUSY_LEN);
                chk("busy_in_done", busy, 1'b0);
            end
        end

        if (!reset_n) begin
            rlen = 0;
            plen = 0;
        end else begin
            if (puf_reset) rlen = rlen + 1;
            else if (rlen != 0) begin
                chk("clear_len", rlen, 2);
                chk("run_after_clear", puf_run, 1'b1);
                rlen = 0;
            end
            if (puf_run) plen = plen + 1;
            else if (plen != 0) begin
                chk("run_len", plen, 1);
                plen = 0;
            end
        end

        if (busy) busy_len = busy_len + 1;
        else busy_len = 0;
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) tmo_req = tmo_req + 1;
    endtask

    task automatic run_acq(input logic [7:0] sd, input int md, input logic [31:0] rsp,
                           input logic [5:0] un, input logic [7:0] ch, input bit poke);
        done_exp_t x;
        @(negedge clk);
        mode  = md;
        seed  = sd;
        start = 1'b1;
        x.resp = rsp;
        x.unst = un;
        x.chal = ch;
        x.start_cyc = cyc;
        done_q.push_back(x);
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (50) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(BUSY_LEN + 200);
        // start during the DONE cycle must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        snap_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, ch, un, rsp});
        repeat (3) @(negedge clk);
        snap_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, ch, un, rsp});
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b1;
        seed       = 8'hA5;
        puf_result = 1'b0;
        repeat (3) @(negedge clk);
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        snap_q.push_back('0);
        repeat (3) @(negedge clk);

        run_acq(8'h10, 0, 32'hFFFF_FFFF, 6'd0,  8'h30, 1'b0);
        run_acq(8'hFE, 1, 32'h5555_5555, 6'd0,  8'h1E, 1'b0);
        run_acq(8'h00, 2, 32'hFFFF_FFFF, 6'd32, 8'h20, 1'b0);
        run_acq(8'h80, 3, 32'h0000_0000, 6'd32, 8'hA0, 1'b0);
        run_acq(8'h33, 4, 32'hFFFF_FFFF, 6'd0,  8'h53, 1'b1);

        // Abort mid-acquisition: no expectation is queued, so any done fails.
        @(negedge clk);
        mode  = 0;
        seed  = 8'h40;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (1499) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        snap_q.push_back('0);
        repeat (BUSY_LEN + 100) @(negedge clk);

        run_acq(8'h05, 0, 32'hFFFF_FFFF, 6'd0, 8'h25, 1'b0);

        repeat (4) @(negedge clk);
        if (done_q.size() != 0 || snap_q.size() != 0) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL pending_checks: got %0d outstanding, required 0",
                     done_q.size() + snap_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
